// File: rtl/display_fifo_pkg.sv
// display_fifo_pkg: shared constants and helpers for the display pixel FIFO.
package display_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;
  localparam int ERR_CNT_W      = 16;

  // Pointer/count width: address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/display_fifo_ram.sv
// display_fifo_ram: simple dual-port storage, one write and one synchronous read port.
// A read and a write to the same address in one cycle return the old word.
module display_fifo_ram #(
  parameter int DATA_WIDTH = 48,
  parameter int DEPTH      = 512
) (
  input  logic                     clk_i,
  input  logic                     a_rstn_i,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered output, cleared by reset, holds when not reading.
  always_ff @(posedge clk_i or negedge a_rstn_i) begin
    if (!a_rstn_i) rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/display_pixel_fifo.sv
// display_pixel_fifo: single-clock FIFO between the display DMA and the pixel pipe.
// Standard (1-cycle read latency) or first-word-fall-through read mode via FWFT.
// Define DISPLAY_FIFO_ERR_CNT_EN to build the saturating overflow/underflow counters.
module display_pixel_fifo
  import display_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 48,
  parameter int DEPTH      = 512,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_THRESH  = DEPTH - 8,
  parameter int AE_THRESH  = 8
) (
  input  logic                     clk_i,
  input  logic                     a_rstn_i,
  input  logic                     wr_en_i,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     rd_en_i,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     rd_valid_o,
  output logic                     full_o,
  output logic                     almost_full_o,
  output logic                     empty_o,
  output logic                     almost_empty_o,
  output logic                     overflow_o,
  output logic                     underflow_o,
  output logic [$clog2(DEPTH):0]   datacount_o,
  output logic [ERR_CNT_W-1:0]     ovf_cnt_o,
  output logic [ERR_CNT_W-1:0]     udf_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] ONE      = PW'(1);
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LVL   = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL   = PW'(AE_THRESH);

  logic [PW-1:0] wr_ptr, rd_ptr, count, count_nxt;
  logic          wr_acc, rd_acc, ram_re, ram_has;
  logic          rd_vld, empty_r;

  // A same-cycle pop never frees room for a write, nor a push make a read legal.
  assign wr_acc  = wr_en_i && !full_o;
  assign rd_acc  = rd_en_i && !empty_o;
  // Words sitting in RAM that have not been fetched yet (wrap bit resolves full vs empty).
  assign ram_has = (wr_ptr != rd_ptr);

  assign rd_valid_o  = rd_vld;
  assign empty_o     = empty_r;
  assign datacount_o = count;

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)      count_nxt = count + ONE;
    else if (rd_acc && !wr_acc) count_nxt = count - ONE;
  end

  // Write pointer, occupancy, level flags and reject pulses.
  always_ff @(posedge clk_i or negedge a_rstn_i) begin
    if (!a_rstn_i) begin
      wr_ptr         <= '0;
      count          <= '0;
      full_o         <= 1'b0;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      count          <= count_nxt;
      full_o         <= (count_nxt == FULL_LVL);
      almost_full_o  <= (count_nxt >= AF_LVL);
      almost_empty_o <= (count_nxt <= AE_LVL);
      overflow_o     <= wr_en_i && full_o;
      underflow_o    <= rd_en_i && empty_o;
    end
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // The RAM read register is the presentation stage; it is refilled whenever it
    // is empty or being popped, so back-to-back pops stream one word per cycle.
    assign ram_re  = ram_has && (!rd_vld || rd_acc);
    assign empty_r = !rd_vld;

    // Fetch pointer and presentation-stage valid.
    always_ff @(posedge clk_i or negedge a_rstn_i) begin
      if (!a_rstn_i) begin
        rd_ptr <= '0;
        rd_vld <= 1'b0;
      end else if (ram_re) begin
        rd_ptr <= rd_ptr + ONE;
        rd_vld <= 1'b1;
      end else if (rd_acc) begin
        rd_vld <= 1'b0;
      end
    end
  end else begin : g_std
    // An accepted pop always has a word in RAM; the guard just keeps the read port quiet otherwise.
    assign ram_re = rd_acc && ram_has;

    // Read pointer, one-cycle read-valid strobe and registered empty flag.
    always_ff @(posedge clk_i or negedge a_rstn_i) begin
      if (!a_rstn_i) begin
        rd_ptr  <= '0;
        rd_vld  <= 1'b0;
        empty_r <= 1'b1;
      end else begin
        if (ram_re) rd_ptr <= rd_ptr + ONE;
        rd_vld  <= ram_re;
        empty_r <= (count_nxt == '0);
      end
    end
  end

  display_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk_i    (clk_i),
    .a_rstn_i (a_rstn_i),
    .we       (wr_acc),
    .waddr    (wr_ptr[AW-1:0]),
    .wdata    (wdata),
    .re       (ram_re),
    .raddr    (rd_ptr[AW-1:0]),
    .rdata    (rdata)
  );

`ifdef DISPLAY_FIFO_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] ovf_cnt, udf_cnt;

  // Saturating counts of rejected writes and reads; only reset clears them.
  always_ff @(posedge clk_i or negedge a_rstn_i) begin
    if (!a_rstn_i) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (wr_en_i && full_o && (ovf_cnt != '1))  ovf_cnt <= ovf_cnt + 1'b1;
      if (rd_en_i && empty_o && (udf_cnt != '1)) udf_cnt <= udf_cnt + 1'b1;
    end
  end

  assign ovf_cnt_o = ovf_cnt;
  assign udf_cnt_o = udf_cnt;
`else
  assign ovf_cnt_o = '0;
  assign udf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_display_pixel_fifo.sv
// tb_display_pixel_fifo: standard and FWFT instances driven with the same stimulus,
// each checked against a queue-based reference model.
module tb_display_pixel_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 3;
  localparam int CW    = 5;
`ifdef DISPLAY_FIFO_ERR_CNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wdata = '0;

  logic [DW-1:0] s_rdata, f_rdata;
  logic          s_vld, s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
  logic          f_vld, f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
  logic [CW-1:0] s_cnt, f_cnt;
  logic [15:0]   s_ovfc, s_udfc, f_ovfc, f_udfc;

  always #5 clk = ~clk;

  display_pixel_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
    .clk_i(clk), .a_rstn_i(rst_n), .wr_en_i(wr_en), .wdata(wdata), .rd_en_i(rd_en),
    .rdata(s_rdata), .rd_valid_o(s_vld), .full_o(s_full), .almost_full_o(s_af),
    .empty_o(s_empty), .almost_empty_o(s_ae), .overflow_o(s_ovf), .underflow_o(s_udf),
    .datacount_o(s_cnt), .ovf_cnt_o(s_ovfc), .udf_cnt_o(s_udfc));

  display_pixel_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
    .clk_i(clk), .a_rstn_i(rst_n), .wr_en_i(wr_en), .wdata(wdata), .rd_en_i(rd_en),
    .rdata(f_rdata), .rd_valid_o(f_vld), .full_o(f_full), .almost_full_o(f_af),
    .empty_o(f_empty), .almost_empty_o(f_ae), .overflow_o(f_ovf), .underflow_o(f_udf),
    .datacount_o(f_cnt), .ovf_cnt_o(f_ovfc), .udf_cnt_o(f_udfc));

  int n_assert = 0, n_fail = 0, cyc = 0;

  // Standard-mode model: contents, last read word, reject pulses and event totals.
  logic [DW-1:0] sq[$];
  logic [DW-1:0] s_rd_exp;
  bit            s_vld_exp, s_ovf_exp, s_udf_exp;
  int            s_ovf_n, s_udf_n;

  // FWFT model: contents with write cycles; a word shows up two cycles after its
  // write, or the cycle after its predecessor is popped, whichever is later.
  logic [DW-1:0] fq[$];
  int            fw[$];
  int            f_last_pop;
  bit            f_ovf_exp, f_udf_exp;
  int            f_ovf_n, f_udf_n;

  function automatic bit f_visible(int c);
    int t;
    if (fq.size() == 0) return 1'b0;
    t = (fw[0] + 2 > f_last_pop + 1) ? fw[0] + 2 : f_last_pop + 1;
    return c >= t;
  endfunction

  function automatic int sat16(int n);
    return (n > 65535) ? 65535 : n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sq.delete(); fq.delete(); fw.delete();
    s_rd_exp = '0; s_vld_exp = 0; s_ovf_exp = 0; s_udf_exp = 0; s_ovf_n = 0; s_udf_n = 0;
    f_last_pop = -100; f_ovf_exp = 0; f_udf_exp = 0; f_ovf_n = 0; f_udf_n = 0;
  endtask

  task automatic check_all(input string ph);
    int n, m;
    bit fv;
    n = sq.size(); m = fq.size(); fv = f_visible(cyc);
    chk({ph, ":s_cnt"},   s_cnt,   n);
    chk({ph, ":s_full"},  s_full,  n == DEPTH);
    chk({ph, ":s_af"},    s_af,    n >= AF);
    chk({ph, ":s_ae"},    s_ae,    n <= AE);
    chk({ph, ":s_empty"}, s_empty, n == 0);
    chk({ph, ":s_vld"},   s_vld,   s_vld_exp);
    chk({ph, ":s_rdata"}, s_rdata, s_rd_exp);
    chk({ph, ":s_ovf"},   s_ovf,   s_ovf_exp);
    chk({ph, ":s_udf"},   s_udf,   s_udf_exp);
    chk({ph, ":s_ovfc"},  s_ovfc,  ERR_EN ? sat16(s_ovf_n) : 0);
    chk({ph, ":s_udfc"},  s_udfc,  ERR_EN ? sat16(s_udf_n) : 0);
    chk({ph, ":f_cnt"},   f_cnt,   m);
    chk({ph, ":f_full"},  f_full,  m == DEPTH);
    chk({ph, ":f_af"},    f_af,    m >= AF);
    chk({ph, ":f_ae"},    f_ae,    m <= AE);
    chk({ph, ":f_vld"},   f_vld,   fv);
    chk({ph, ":f_empty"}, f_empty, !fv);
    if (fv) chk({ph, ":f_rdata"}, f_rdata, fq[0]);
    chk({ph, ":f_ovf"},   f_ovf,   f_ovf_exp);
    chk({ph, ":f_udf"},   f_udf,   f_udf_exp);
    chk({ph, ":f_ovfc"},  f_ovfc,  ERR_EN ? sat16(f_ovf_n) : 0);
    chk({ph, ":f_udfc"},  f_udfc,  ERR_EN ? sat16(f_udf_n) : 0);
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge state.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input string ph);
    bit sw, sr, fwa, fr;
    logic [DW-1:0] tmp;
    int tmpi;
    wr_en = w; wdata = d; rd_en = r;
    sw  = w && (sq.size() < DEPTH);
    sr  = r && (sq.size() > 0);
    fwa = w && (fq.size() < DEPTH);
    fr  = r && f_visible(cyc);
    @(posedge clk); #1;
    s_ovf_exp = w && !sw; s_udf_exp = r && !sr;
    s_ovf_n += int'(s_ovf_exp); s_udf_n += int'(s_udf_exp);
    s_vld_exp = sr;
    if (sr) s_rd_exp = sq.pop_front();
    if (sw) sq.push_back(d);
    f_ovf_exp = w && !fwa; f_udf_exp = r && !fr;
    f_ovf_n += int'(f_ovf_exp); f_udf_n += int'(f_udf_exp);
    if (fr) begin tmp = fq.pop_front(); tmpi = fw.pop_front(); f_last_pop = cyc; end
    if (fwa) begin fq.push_back(d); fw.push_back(cyc); end
    cyc++;
    check_all(ph);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset:f_rdata", f_rdata, 0);
    @(negedge clk) rst_n = 1'b1;

    // Fill to full with 0..15, threshold edges along the way
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0, "fill");
      if (i == 2)  chk("ae_3words", s_ae, 1);
      if (i == 3)  chk("ae_4words", s_ae, 0);
      if (i == 10) chk("af_11words", s_af, 0);
      if (i == 11) chk("af_12words", s_af, 1);
    end
    chk("full_at_16", s_full, 1);
    chk("cnt_at_16", s_cnt, 16);
    step(1'b1, 16'hDEAD, 1'b0, "ovf");
    chk("ovf_pulse", s_ovf, 1);
    chk("ovf_cnt_hold", s_cnt, 16);
    step(1'b0, '0, 1'b0, "ovf_gap");

    // Drain in order
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1, "drain");
      chk("drain_data", s_rdata, i);
    end
    chk("drain_empty", s_empty, 1);

    // Underflow at empty
    step(1'b0, '0, 1'b1, "udf");
    chk("udf_pulse", s_udf, 1);
    chk("udf_vld", s_vld, 0);
    chk("udf_cnt", s_cnt, 0);

    // Simultaneous read+write at count 5, at full, at empty
    for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h100 + i), 1'b0, "to5");
    step(1'b1, 16'h1AA, 1'b1, "rw5");
    chk("rw5_cnt", s_cnt, 5);
    for (int i = 0; i < 11; i++) step(1'b1, DW'(16'h200 + i), 1'b0, "to16");
    step(1'b1, 16'h2BB, 1'b1, "rw_full");
    chk("rw_full_ovf", s_ovf, 1);
    chk("rw_full_cnt", s_cnt, 15);
    for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1, "to0");
    step(1'b1, 16'h3CC, 1'b1, "rw_empty");
    chk("rw_empty_udf", s_udf, 1);
    chk("rw_empty_cnt", s_cnt, 1);
    step(1'b0, '0, 1'b0, "settle");
    step(1'b0, '0, 1'b1, "pop1");
    step(1'b0, '0, 1'b0, "idle");

    // FWFT: first-word latency
    step(1'b1, 16'h0ABC, 1'b0, "fwft_w");
    chk("fwft_c1_vld", f_vld, 0);
    step(1'b0, '0, 1'b0, "fwft_c2");
    chk("fwft_c2_vld", f_vld, 1);
    chk("fwft_c2_data", f_rdata, 16'h0ABC);
    step(1'b0, '0, 1'b1, "fwft_pop");

    // FWFT: back-to-back pops of 8 words
    for (int i = 0; i < 8; i++) step(1'b1, DW'(16'h400 + i), 1'b0, "b2b_fill");
    run = 0;
    for (int i = 0; i < 8; i++) begin
      if (f_vld === 1'b1) run++;
      step(1'b0, '0, 1'b1, "b2b_pop");
    end
    chk("fwft_b2b_valid_cycles", run, 8);
    step(1'b0, '0, 1'b0, "b2b_idle");

    // Randomised traffic: write-heavy then read-heavy
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 99) < 70), DW'($urandom), ($urandom_range(0, 99) < 40), "rand_w");
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 99) < 40), DW'($urandom), ($urandom_range(0, 99) < 70), "rand_r");

    // Reset mid-burst at count 9
    for (int k = 0; k < 40 && (sq.size() + fq.size()) > 0; k++) step(1'b0, '0, 1'b1, "pre_rst");
    chk("pre_rst_empty", s_cnt, 0);
    for (int i = 0; i < 9; i++) step(1'b1, DW'(16'h500 + i), 1'b0, "burst");
    chk("burst_cnt", s_cnt, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s_empty", s_empty, 1);
    chk("rst_s_cnt", s_cnt, 0);
    chk("rst_f_empty", f_empty, 1);
    chk("rst_f_cnt", f_cnt, 0);
    chk("rst_f_vld", f_vld, 0);
    chk("rst_s_ovfc", s_ovfc, 0);
    chk("rst_s_udfc", s_udfc, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    step(1'b0, '0, 1'b0, "post_rst");
    for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h600 + i), 1'b0, "post_w");
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, "post_r");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
